sram_port_arbiter: RTL and testbench

//   Shares one single-outstanding SRAM-like memory port between the IF stage
//   (instruction fetch) and the MEM stage (load/store). Accepts one request at
//   a time from each requester, sequences the bus address and data phases, and

---
 rtl/sram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-outstanding SRAM-like memory port between instruction
//   fetch (inst_*) and load/store (data_*). Each requester holds its request
//   and fields stable until its done pulse. Each grant runs through three
//   phases: an address phase (mem_req held until mem_addr_ok), a data phase
//   (waiting for mem_data_ok), and then a one-cycle done pulse to the owner.
//   Data accesses normally win over fetches. A fetch wins instead once
//   starve_cnt has reached STARVE_MAX.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request and byte address
//   inst_rdata/inst_done          fetched word and its completion pulse
//   data_req/wr/wstrb/addr/wdata  load/store request and fields
//   data_rdata/data_done          load data and its completion pulse
//   mem_req/wr/wstrb/addr/wdata   bus address phase (registered, stable while mem_req)
//   mem_addr_ok/mem_data_ok       bus address accept and data phase complete
//   mem_rdata                     bus read data, valid with mem_data_ok
//   stallreq_if/stallreq_mem      combinational stall requests toward the pipeline
module sram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    // load/store requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    // memory port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    // pipeline stall requests
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StWait
    } state_t;

    typedef enum logic {
        OwnInst,
        OwnData
    } owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_done_q, inst_done_d;
    logic        data_done_q, data_done_d;

    // A requester in its done cycle still holds req; it must not be granted again.
    logic inst_elig;
    logic data_elig;
    logic inst_wins_starve;

    assign inst_elig        = inst_req & ~inst_done_q;
    assign data_elig        = data_req & ~data_done_q;
    assign inst_wins_starve = inst_elig & (starve_cnt_q == StarveMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnInst;
            starve_cnt_q <= 4'd0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_elig && !inst_wins_starve) begin
                    state_d     = StAddr;
                    owner_d     = OwnData;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = data_wr;
                    mem_wstrb_d = data_wr ? data_wstrb : 4'b0000;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    // Count grants that overtake a waiting fetch; saturate at the limit.
                    if (inst_req && (starve_cnt_q < StarveMax)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (inst_elig) begin
                    state_d      = StAddr;
                    owner_d      = OwnInst;
                    starve_cnt_d = 4'd0;
                    mem_req_d    = 1'b1;
                    mem_wr_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    mem_addr_d   = inst_addr;
                    mem_wdata_d  = 32'h0;
                end
            end
            StAddr: begin
                if (mem_addr_ok) begin
                    state_d   = StWait;
                    mem_req_d = 1'b0;
                end
            end
            StWait: begin
                if (mem_data_ok) begin
                    state_d = StIdle;
                    if (owner_q == OwnInst) begin
                        inst_rdata_d = mem_rdata;
                        inst_done_d  = 1'b1;
                    end else begin
                        // Stores leave the last load result untouched.
                        if (!mem_wr_q) begin
                            data_rdata_d = mem_rdata;
                        end
                        data_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign inst_rdata   = inst_rdata_q;
    assign inst_done    = inst_done_q;
    assign data_rdata   = data_rdata_q;
    assign data_done    = data_done_q;
    assign mem_req      = mem_req_q;
    assign mem_wr       = mem_wr_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign stallreq_if  = inst_req & ~inst_done_q;
    assign stallreq_mem = data_req & ~data_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    // default instance (STARVE_MAX = 3)
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_done, data_done, mem_req, mem_wr, stallreq_if, stallreq_mem;
    logic [3:0]  mem_wstrb;

    // second instance with STARVE_MAX = 1, same stimulus
    logic [31:0] s1_inst_rdata, s1_data_rdata, s1_mem_addr, s1_mem_wdata;
    logic        s1_inst_done, s1_data_done, s1_mem_req, s1_mem_wr;
    logic        s1_stallreq_if, s1_stallreq_mem;
    logic [3:0]  s1_mem_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .inst_done    (inst_done),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_done    (data_done),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    sram_port_arbiter #(
        .STARVE_MAX (1)
    ) dut_s1 (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (s1_inst_rdata),
        .inst_done    (s1_inst_done),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (s1_data_rdata),
        .data_done    (s1_data_done),
        .mem_req      (s1_mem_req),
        .mem_wr       (s1_mem_wr),
        .mem_wstrb    (s1_mem_wstrb),
        .mem_addr     (s1_mem_addr),
        .mem_wdata    (s1_mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .stallreq_if  (s1_stallreq_if),
        .stallreq_mem (s1_stallreq_mem)
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;      // value the bus returns in the data phase
        int unsigned addr_dly;   // ADDR cycles before addr_ok
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;     // requester's rdata after done
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        // cycle 0: request in IDLE; a stray addr_ok must be ignored
        if (v.is_data) begin
            data_req   = 1'b1;
            data_wr    = v.wr;
            data_wstrb = v.wstrb;
            data_addr  = v.addr;
            data_wdata = v.wdata;
        end else begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b0;
        #1;
        chk({p, " idle mem_req"}, 32'(mem_req), 32'd0);
        chk({p, " req stall"}, 32'(v.is_data ? stallreq_mem : stallreq_if), 32'd1);
        step();
        // ADDR phase: fields stable, stray data_ok ignored
        for (int d = 0; d <= int'(v.addr_dly); d++) begin
            mem_addr_ok = (d == int'(v.addr_dly));
            mem_data_ok = (d != int'(v.addr_dly));
            mem_rdata   = 32'hBAD0_0000 | 32'(d);
            #1;
            chk($sformatf("%s addr%0d mem_req", p, d), 32'(mem_req), 32'd1);
            chk($sformatf("%s addr%0d mem_wr", p, d), 32'(mem_wr), 32'(v.wr));
            chk($sformatf("%s addr%0d mem_wstrb", p, d), 32'(mem_wstrb), 32'(v.exp_wstrb));
            chk($sformatf("%s addr%0d mem_addr", p, d), mem_addr, v.addr);
            chk($sformatf("%s addr%0d mem_wdata", p, d), mem_wdata, v.exp_wdata);
            chk($sformatf("%s addr%0d stall", p, d),
                32'(v.is_data ? stallreq_mem : stallreq_if), 32'd1);
            chk($sformatf("%s addr%0d done", p, d), 32'(inst_done | data_done), 32'd0);
            step();
        end
        // WAIT phase
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = v.rdata;
        #1;
        chk({p, " wait mem_req"}, 32'(mem_req), 32'd0);
        chk({p, " wait done"}, 32'(inst_done | data_done), 32'd0);
        step();
        // done cycle
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        #1;
        chk({p, " done"}, 32'(v.is_data ? data_done : inst_done), 32'd1);
        chk({p, " other done"}, 32'(v.is_data ? inst_done : data_done), 32'd0);
        chk({p, " rdata"}, v.is_data ? data_rdata : inst_rdata, v.exp_rd);
        chk({p, " done stall"}, 32'(v.is_data ? stallreq_mem : stallreq_if), 32'd0);
        inst_req = 1'b0;
        data_req = 1'b0;
        step();
        chk({p, " post done"}, 32'(inst_done | data_done), 32'd0);
        chk({p, " post rdata"}, v.is_data ? data_rdata : inst_rdata, v.exp_rd);
        chk({p, " post mem_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        // fetch, load, store (slow addr_ok), load with stray strobes, fetch
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C01_1234, 0,
                    4'h0, 32'h0, 32'h3C01_1234};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0, 32'h1122_3344, 0,
                    4'h0, 32'h0, 32'h1122_3344};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h8000_0020, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5,
                    4'b0011, 32'hDEAD_BEEF, 32'h1122_3344};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h8000_0044, 32'h0000_0077, 32'hA5A5_0F0F, 2,
                    4'h0, 32'h0000_0077, 32'hA5A5_0F0F};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0004, 32'h0, 32'h0000_0013, 1,
                    4'h0, 32'h0, 32'h0000_0013};

        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst dones", 32'({inst_done, data_done}), 32'd0);
        chk("rst inst_rdata", inst_rdata, 32'h0);
        chk("rst data_rdata", data_rdata, 32'h0);
        chk("rst stalls", 32'({stallreq_if, stallreq_mem}), 32'd0);
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Simultaneous requests: data first, fetch granted in the data done cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0010; data_wdata = 32'h0;
        step();
        mem_addr_ok = 1'b1;
        #1;
        chk("arb first addr", mem_addr, 32'h8000_0010);
        chk("arb first req", 32'(mem_req), 32'd1);
        chk("arb starve after data", 32'(dut.starve_cnt_q), 32'd1);
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("arb data_done", 32'(data_done), 32'd1);
        chk("arb data_rdata", data_rdata, 32'h55AA_55AA);
        chk("arb inst still stalled", 32'(stallreq_if), 32'd1);
        data_req = 1'b0;
        step();
        mem_addr_ok = 1'b1;
        #1;
        chk("arb second addr", mem_addr, 32'hBFC0_0010);
        chk("arb second req", 32'(mem_req), 32'd1);
        chk("arb starve cleared", 32'(dut.starve_cnt_q), 32'd0);
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h2402_0001;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("arb inst_done", 32'(inst_done), 32'd1);
        chk("arb inst_rdata", inst_rdata, 32'h2402_0001);
        inst_req = 1'b0;
        step();

        // Starvation limit: STARVE_MAX=1 lets the fetch win a contest after one overtake.
        rst = 1'b1;
        step();
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        step();
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0001;
        step();
        mem_data_ok = 1'b0;
        // inst done cycle: inst_req still held, data overtakes it
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0200;
        #1;
        chk("starve inst_done", 32'(inst_done & s1_inst_done), 32'd1);
        step();
        inst_req = 1'b0;
        mem_addr_ok = 1'b1;
        #1;
        chk("starve d1 addr", mem_addr, 32'h8000_0200);
        chk("starve d1 addr s1", s1_mem_addr, 32'h8000_0200);
        chk("starve cnt s1", 32'(dut_s1.starve_cnt_q), 32'd1);
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0002;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("starve data_done s1", 32'(s1_data_done), 32'd1);
        data_req = 1'b0;
        step();
        // contest: both eligible together
        inst_req = 1'b1; inst_addr = 32'h0000_0104;
        data_req = 1'b1; data_addr = 32'h8000_0204;
        step();
        chk("contest max3 data wins", mem_addr, 32'h8000_0204);
        chk("contest max3 cnt", 32'(dut.starve_cnt_q), 32'd2);
        chk("contest max1 inst wins", s1_mem_addr, 32'h0000_0104);
        chk("contest max1 cnt", 32'(dut_s1.starve_cnt_q), 32'd0);

        // Reset during WAIT abandons the transaction; late data_ok is ignored.
        rst = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        step();
        rst = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0300;
        step();
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid in wait", 32'(mem_req), 32'd0);
        step();
        rst = 1'b0;
        data_req = 1'b0;
        #1;
        chk("rstmid mem_addr", mem_addr, 32'h0);
        chk("rstmid no done", 32'(data_done), 32'd0);
        chk("rstmid stall", 32'(stallreq_mem), 32'd0);
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rstmid late ok done", 32'(data_done), 32'd0);
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("rstmid after ok done", 32'(data_done), 32'd0);
        chk("rstmid rdata kept", data_rdata, 32'h0);
        chk("rstmid idle req", 32'(mem_req), 32'd0);
        step();
        chk("rstmid still idle", 32'(mem_req), 32'd0);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0400;
        step();
        chk("rstmid new req", 32'(mem_req), 32'd1);
        chk("rstmid new addr", mem_addr, 32'hBFC0_0400);
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("rstmid new done", 32'(inst_done), 32'd1);
        chk("rstmid new rdata", inst_rdata, 32'h1234_5678);
        inst_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
